// File: rtl/dbg_host_bridge_pkg.sv
// rtl/dbg_host_bridge_pkg.sv - opcodes, response codes and FSM states for the host byte-link bridge
package dbg_host_bridge_pkg;

  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'hAA;
  localparam logic [7:0] RSP_TMO = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DLO   = 3'd2,
    ST_DHI   = 3'd3,
    ST_WRITE = 3'd4,
    ST_READ  = 3'd5,
    ST_TX0   = 3'd6,
    ST_TX1   = 3'd7
  } state_e;

endpackage

// File: rtl/dbg_host_bridge.sv
// rtl/dbg_host_bridge.sv - parses host command bytes into single debug-bus accesses
// and returns an ack byte, read data or a timeout code on the byte link.
module dbg_host_bridge
  import dbg_host_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  dbg_a,
  output logic [15:0] dbg_di,
  output logic        dbg_we,
  output logic        dbg_rd,
  input  logic [15:0] dbg_do,
  input  logic        dbg_ready,
  output logic        rx_drop,
  output logic        busy
);

  localparam int unsigned   CW       = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        is_wr_q, is_wr_d;
  // Only the upper byte of the read word outlives the READ cycle; the low byte goes straight to tx_data.
  logic [7:0]  hold_hi_q, hold_hi_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  dbg_a_q, dbg_a_d;
  logic [15:0] dbg_di_q, dbg_di_d;
  logic        dbg_we_q, dbg_we_d;
  logic        dbg_rd_q, dbg_rd_d;
  logic        rx_drop_q, rx_drop_d;
  logic        busy_q, busy_d;

  logic timed_out;
  logic tx_fire;
  logic byte_taken;

  assign timed_out = (cnt_q == TMO_LAST);
  assign tx_fire   = tx_valid_q & tx_ready;

  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    hold_hi_d  = hold_hi_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    dbg_a_d    = dbg_a_q;
    dbg_di_d   = dbg_di_q;
    dbg_we_d   = dbg_we_q;
    dbg_rd_d   = dbg_rd_q;
    rx_drop_d  = 1'b0;
    byte_taken = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid && rx_data == OP_WR) begin
          is_wr_d = 1'b1;
          state_d = ST_ADDR;
        end else if (rx_valid && rx_data == OP_RD) begin
          is_wr_d = 1'b0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (rx_valid) begin
          byte_taken = 1'b1;
          dbg_a_d    = rx_data;
          if (is_wr_q) begin
            state_d = ST_DLO;
          end else begin
            dbg_rd_d = 1'b1;
            state_d  = ST_READ;
          end
        end else if (timed_out) begin
          state_d = ST_IDLE;
        end
      end
      ST_DLO: begin
        if (rx_valid) begin
          byte_taken     = 1'b1;
          dbg_di_d[7:0]  = rx_data;
          state_d        = ST_DHI;
        end else if (timed_out) begin
          state_d = ST_IDLE;
        end
      end
      ST_DHI: begin
        if (rx_valid) begin
          byte_taken     = 1'b1;
          dbg_di_d[15:8] = rx_data;
          dbg_we_d       = 1'b1;
          state_d        = ST_WRITE;
        end else if (timed_out) begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        // Ready outranks a coincident timeout, and the strobe drops right away so the
        // downstream block sees exactly one access.
        if (dbg_ready || timed_out) begin
          dbg_we_d   = 1'b0;
          tx_data_d  = dbg_ready ? RSP_ACK : RSP_TMO;
          tx_valid_d = 1'b1;
          state_d    = ST_TX1;
        end
      end
      ST_READ: begin
        if (dbg_ready) begin
          dbg_rd_d   = 1'b0;
          hold_hi_d  = dbg_do[15:8];
          tx_data_d  = dbg_do[7:0];
          tx_valid_d = 1'b1;
          state_d    = ST_TX0;
        end else if (timed_out) begin
          dbg_rd_d   = 1'b0;
          tx_data_d  = RSP_TMO;
          tx_valid_d = 1'b1;
          state_d    = ST_TX1;
        end
      end
      ST_TX0: begin
        if (tx_fire) begin
          tx_data_d = hold_hi_q;
          state_d   = ST_TX1;
        end
      end
      ST_TX1: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (rx_valid && (state_q inside {ST_WRITE, ST_READ, ST_TX0, ST_TX1})) begin
      rx_drop_d = 1'b1;
    end

    if (state_d != state_q || byte_taken) begin
      cnt_d = '0;
    end else if (state_q inside {ST_ADDR, ST_DLO, ST_DHI, ST_WRITE, ST_READ}) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      is_wr_q    <= 1'b0;
      hold_hi_q  <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      dbg_a_q    <= 8'h00;
      dbg_di_q   <= 16'h0000;
      dbg_we_q   <= 1'b0;
      dbg_rd_q   <= 1'b0;
      rx_drop_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_wr_q    <= is_wr_d;
      hold_hi_q  <= hold_hi_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      dbg_a_q    <= dbg_a_d;
      dbg_di_q   <= dbg_di_d;
      dbg_we_q   <= dbg_we_d;
      dbg_rd_q   <= dbg_rd_d;
      rx_drop_q  <= rx_drop_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign dbg_a    = dbg_a_q;
  assign dbg_di   = dbg_di_q;
  assign dbg_we   = dbg_we_q;
  assign dbg_rd   = dbg_rd_q;
  assign rx_drop  = rx_drop_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_dbg_host_bridge.sv
// tb/tb_dbg_host_bridge.sv - directed and randomized packets against a packet-level response model
module tb_dbg_host_bridge;
  import dbg_host_bridge_pkg::*;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  dbg_a;
  logic [15:0] dbg_di;
  logic        dbg_we;
  logic        dbg_rd;
  logic [15:0] dbg_do = 16'h0000;
  logic        dbg_ready;
  logic        rx_drop;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  int ready_delay  = 0;
  int acc_age      = 0;
  int stall_mode   = 0;
  logic manual_ready = 1'b1;

  logic [7:0]  tx_log[$];
  logic [24:0] acc_log[$];
  int we_cyc = 0, rd_cyc = 0, drop_cyc = 0, stall_viol = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always #5 clk = ~clk;

  // Target answers once the request has been held for ready_delay cycles (0 = combinational).
  assign dbg_ready = (dbg_we || dbg_rd) && (acc_age >= ready_delay);

  dbg_host_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .dbg_a(dbg_a), .dbg_di(dbg_di), .dbg_we(dbg_we), .dbg_rd(dbg_rd),
    .dbg_do(dbg_do), .dbg_ready(dbg_ready),
    .rx_drop(rx_drop), .busy(busy)
  );

  always @(posedge clk) begin
    acc_age <= (dbg_we || dbg_rd) ? acc_age + 1 : 0;
    if (tx_valid && tx_ready) tx_log.push_back(tx_data);
    if ((dbg_we || dbg_rd) && dbg_ready) acc_log.push_back({dbg_we, dbg_a, dbg_di});
    if (dbg_we) we_cyc <= we_cyc + 1;
    if (dbg_rd) rd_cyc <= rd_cyc + 1;
    if (rx_drop) drop_cyc <= drop_cyc + 1;
    if (prev_stall && (!tx_valid || tx_data !== prev_data)) stall_viol <= stall_viol + 1;
    prev_stall <= tx_valid && !tx_ready;
    prev_data  <= tx_data;
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (stall_mode == 1)      tx_ready = 1'($urandom_range(0, 1));
      else if (stall_mode == 2) tx_ready = manual_ready;
      else                      tx_ready = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || tx_valid) && n < 400) begin
      tick();
      n++;
    end
    chk("idle_bound", 32'(n < 400), 32'd1);
  endtask

  // Model: a request held for delay+1 cycles succeeds iff that fits inside the T-cycle window.
  task automatic run_pkt(input bit wr, input logic [7:0] addr, input logic [15:0] data,
                         input int delay, input logic [15:0] rdv, input bit ovr);
    int tb0 = tx_log.size();
    int ab0 = acc_log.size();
    int wb0 = we_cyc;
    int rb0 = rd_cyc;
    int db0 = drop_cyc;
    bit ok = (delay <= T - 1);
    int cyc = ok ? delay + 1 : T;
    logic [7:0] exp_q[$];
    ready_delay = delay;
    dbg_do      = rdv;
    if (!ok)     exp_q = '{RSP_TMO};
    else if (wr) exp_q = '{RSP_ACK};
    else         exp_q = '{rdv[7:0], rdv[15:8]};
    if (wr) begin
      send_byte(OP_WR); send_byte(addr); send_byte(data[7:0]); send_byte(data[15:8]);
    end else begin
      send_byte(OP_RD); send_byte(addr);
    end
    if (ovr) begin
      tick();
      send_byte(8'h77);
    end
    wait_idle();
    chk("acc_count", 32'(acc_log.size() - ab0), ok ? 32'd1 : 32'd0);
    if (acc_log.size() > ab0) begin
      chk("acc_kind", 32'(acc_log[ab0][24:16]), {23'd0, wr, addr});
      if (wr) chk("acc_data", 32'(acc_log[ab0][15:0]), {16'd0, data});
    end
    chk("we_cycles", 32'(we_cyc - wb0), wr ? 32'(cyc) : 32'd0);
    chk("rd_cycles", 32'(rd_cyc - rb0), wr ? 32'd0 : 32'(cyc));
    chk("tx_len", 32'(tx_log.size() - tb0), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (tb0 + i < tx_log.size()) chk("tx_byte", 32'(tx_log[tb0 + i]), 32'(exp_q[i]));
    end
    chk("drops", 32'(drop_cyc - db0), ovr ? 32'd1 : 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    chk("addr_hold", 32'(dbg_a), 32'(addr));
  endtask

  initial begin
    int tb0, ab0, wb0;
    int n;
    repeat (2) tick();
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_dbg_a", 32'(dbg_a), 32'h00);
    chk("rst_dbg_di", 32'(dbg_di), 32'h0000);
    chk("rst_we_rd", {30'd0, dbg_we, dbg_rd}, 32'd0);
    chk("rst_drop_busy", {30'd0, rx_drop, busy}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Write with combinational ready: one strobe cycle, ack the cycle after.
    ready_delay = 0;
    tb0 = tx_log.size(); wb0 = we_cyc;
    send_byte(OP_WR); send_byte(8'h1B); send_byte(8'h34); send_byte(8'h12);
    chk("wr_we_on", 32'(dbg_we), 32'd1);
    chk("wr_addr", 32'(dbg_a), 32'h1B);
    chk("wr_di", 32'(dbg_di), 32'h1234);
    tick();
    chk("wr_we_off", 32'(dbg_we), 32'd0);
    chk("wr_tx", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, RSP_ACK});
    wait_idle();
    chk("wr_we_cycles", 32'(we_cyc - wb0), 32'd1);
    chk("wr_tx_count", 32'(tx_log.size() - tb0), 32'd1);

    // Read with ready after 5 cycles and a 3-cycle tx stall on the low byte.
    stall_mode = 2; manual_ready = 1'b0;
    ready_delay = 5; dbg_do = 16'hBEEF;
    tb0 = tx_log.size(); wb0 = rd_cyc;
    send_byte(OP_RD); send_byte(8'h20);
    chk("rd_on", 32'(dbg_rd), 32'd1);
    n = 0;
    while (!tx_valid && n < 50) begin tick(); n++; end
    chk("rd_tx_bound", 32'(n < 50), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_lo", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hEF});
      tick();
    end
    manual_ready = 1'b1;
    tick();
    chk("rd_hi_offer", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hBE});
    wait_idle();
    stall_mode = 0;
    chk("rd_cycles6", 32'(rd_cyc - wb0), 32'd6);
    chk("rd_tx_count", 32'(tx_log.size() - tb0), 32'd2);
    if (tx_log.size() >= tb0 + 2) chk("rd_tx_bytes", {16'd0, tx_log[tb0], tx_log[tb0 + 1]}, 32'h0000EFBE);

    // Access timeout and the ready/timeout boundary.
    run_pkt(1'b0, 8'h05, 16'h0000, 9999, 16'h1111, 1'b0);
    run_pkt(1'b1, 8'h06, 16'hA55A, T - 1, 16'h0000, 1'b0);
    run_pkt(1'b0, 8'h07, 16'h0000, T - 1, 16'hC3D2, 1'b0);
    run_pkt(1'b1, 8'h08, 16'h0F0F, T, 16'h0000, 1'b0);

    // Garbage byte, then an abandoned packet; the gap timeout returns to IDLE silently.
    tb0 = tx_log.size(); ab0 = acc_log.size(); wb0 = drop_cyc;
    send_byte(8'h13);
    chk("garbage_busy", 32'(busy), 32'd0);
    send_byte(OP_WR); send_byte(8'h10);
    repeat (T - 1) tick();
    chk("gap_still_busy", 32'(busy), 32'd1);
    tick();
    chk("gap_idle", 32'(busy), 32'd0);
    repeat (5) tick();
    chk("gap_no_access", 32'(acc_log.size() - ab0), 32'd0);
    chk("gap_no_tx", 32'(tx_log.size() - tb0), 32'd0);
    chk("gap_no_drop", 32'(drop_cyc - wb0), 32'd0);
    run_pkt(1'b0, 8'h10, 16'h0000, 2, 16'h4321, 1'b0);

    // Overrun byte during a read wait.
    run_pkt(1'b0, 8'h44, 16'h0000, 5, 16'h9A8B, 1'b1);

    // Reset in the middle of a write access.
    ready_delay = 9999;
    tb0 = tx_log.size();
    send_byte(OP_WR); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
    chk("pre_rst_we", 32'(dbg_we), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outs", {29'd0, dbg_we, tx_valid, busy}, 32'd0);
    chk("rst_async_addr", 32'(dbg_a), 32'h00);
    tick(); tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("rst_no_rsp", 32'(tx_log.size() - tb0), 32'd0);
    run_pkt(1'b1, 8'h5C, 16'h7E81, 1, 16'h0000, 1'b0);

    // Randomized packets with random tx backpressure.
    stall_mode = 1;
    for (int k = 0; k < 24; k++) begin
      logic [7:0] g;
      bit w;
      int sel, d;
      g = 8'($urandom);
      if (g != OP_WR && g != OP_RD) begin
        send_byte(g);
        chk("rand_garbage", 32'(busy), 32'd0);
      end
      w   = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 3);
      d   = (sel == 0) ? 0 : (sel == 3) ? T + $urandom_range(0, 3) : $urandom_range(1, T - 1);
      run_pkt(w, 8'($urandom), 16'($urandom), d, 16'($urandom), (d >= 3) && ($urandom_range(0, 1) == 1));
    end
    stall_mode = 0;
    tick();
    chk("tx_stall_stable", 32'(stall_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
